// File: rtl/alu_result_accumulator.sv
// alu_result_accumulator
//   Sums bursts of CNT unsigned ALU results arriving over valid/ready into one
//   wide total, then presents total, item count and saturation flag downstream
//   with full backpressure. A flush closes a partial burst early.
//   Optional build macro: ACC_SATURATE_EN
//     defined   -> an add with carry-out clamps the total to all-ones and sets
//                  a sticky out_sat for the rest of the burst.
//     undefined -> the total wraps modulo 2^ACC_W and out_sat stays 0.
//   The port list is identical in both builds.
module alu_result_accumulator #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT   = 4,
    parameter int unsigned ACC_W = 6,
    parameter int unsigned CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CW-1:0]    out_count,
    output logic             out_sat
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             sat;
    logic             sat_nxt;

    logic             out_valid_nxt;
    logic [ACC_W-1:0] out_sum_nxt;
    logic [CW-1:0]    out_count_nxt;
    logic             out_sat_nxt;

    logic             in_xfer;
    logic             out_xfer;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] add_res;
    logic             add_sat;
    logic [CW-1:0]    cnt_inc;
    logic             close_burst;

    // Upstream is only stalled while a finished burst waits downstream
    assign in_ready = (state != HOLD);
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign cnt_inc  = cnt + CW'(1);

    // The first datum of a burst starts from zero, later ones add to acc
    assign acc_base = (state == IDLE) ? '0 : acc;

`ifdef ACC_SATURATE_EN
    logic [ACC_W:0] sum_wide;

    // One extra bit catches the carry; once clamped the burst stays clamped
    always_comb begin
        sum_wide = {1'b0, acc_base} + (ACC_W + 1)'(in_data);
        add_sat  = sum_wide[ACC_W] | ((state != IDLE) & sat);
        add_res  = add_sat ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    end
`else
    // Plain modular add; carry-out is intentionally discarded
    always_comb begin
        add_res = acc_base + ACC_W'(in_data);
        add_sat = 1'b0;
    end
`endif

    // Next-state and next-output logic for the burst FSM
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        sat_nxt       = sat;
        out_valid_nxt = out_valid;
        out_sum_nxt   = out_sum;
        out_count_nxt = out_count;
        out_sat_nxt   = out_sat;
        close_burst   = 1'b0;

        case (state)
            IDLE: begin
                // A lone flush here has nothing to close and is dropped
                if (in_xfer) begin
                    acc_nxt = add_res;
                    cnt_nxt = CW'(1);
                    sat_nxt = add_sat;
                    if ((CNT == 1) || flush) begin
                        close_burst = 1'b1;
                    end else begin
                        state_nxt = ACC;
                    end
                end
            end
            ACC: begin
                if (in_xfer) begin
                    acc_nxt = add_res;
                    cnt_nxt = cnt_inc;
                    sat_nxt = add_sat;
                    if ((cnt_inc == CW'(CNT)) || flush) begin
                        close_burst = 1'b1;
                    end
                end else if (flush) begin
                    close_burst = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt     = IDLE;
                    acc_nxt       = '0;
                    cnt_nxt       = '0;
                    sat_nxt       = 1'b0;
                    out_valid_nxt = 1'b0;
                    out_sum_nxt   = '0;
                    out_count_nxt = '0;
                    out_sat_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                sat_nxt   = 1'b0;
            end
        endcase

        // Publish the finished burst; it is held until downstream takes it
        if (close_burst) begin
            state_nxt     = HOLD;
            out_valid_nxt = 1'b1;
            out_sum_nxt   = acc_nxt;
            out_count_nxt = cnt_nxt;
            out_sat_nxt   = sat_nxt;
        end
    end

    // State and output registers; reset discards any partial burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            sat       <= sat_nxt;
            out_valid <= out_valid_nxt;
            out_sum   <= out_sum_nxt;
            out_count <= out_count_nxt;
            out_sat   <= out_sat_nxt;
        end
    end

endmodule
